apb_master_arbiter: RTL and testbench

- Shares one APB3 master port among NREQ independent requesters, e.g. a BFM, a config loader and a debug port.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases.
- Decodes the 16 one-hot PSEL lines from address bits and handles PREADY wait states and PSLVERR.
- A timeout guards against a hung slave that never asserts PREADY.

---
 rtl/apb_arb_pkg.sv | 30 +++
 rtl/apb_rr_picker.sv | 40 ++++
 rtl/apb_master_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// ----------------------------------------------------------------------------
// apb_arb_pkg
// Shared definitions for the APB3 master arbiter:
//   - state_e      : transfer sequencer states (IDLE/SETUP/ACCESS/RESP)
//   - APB_W        : APB address/data width
//   - PSEL_W       : number of one-hot slave selects
//   - SLOT_W       : width of the address slot field decoded into PSEL
//   - slot_to_psel : slot number -> one-hot PSEL vector
// ----------------------------------------------------------------------------
package apb_arb_pkg;

    localparam int APB_W  = 32;
    localparam int PSEL_W = 16;
    localparam int SLOT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [PSEL_W-1:0] slot_to_psel(input logic [SLOT_W-1:0] slot);
        logic [PSEL_W-1:0] sel;
        sel       = '0;
        sel[slot] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// ----------------------------------------------------------------------------
// apb_rr_picker
// Combinational round-robin selection: returns the first set request bit at or
// after the pointer, wrapping modulo NREQ.
// Ports:
//   req_i   : request vector
//   ptr_i   : highest-priority requester index for this arbitration
//   gnt_o   : one-hot winner (all zero when no request)
//   idx_o   : binary index of the winner
//   valid_o : at least one request is set
// ----------------------------------------------------------------------------
module apb_rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            int cand;
            cand = (int'(ptr_i) + off) % NREQ;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// ----------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB3 master port among NREQ requesters. Round-robin arbitration
// in IDLE, then SETUP -> ACCESS (with PREADY wait states and an optional
// timeout) -> RESP, where DONE pulses for the granted requester.
// Ports:
//   PCLK, PRESET            : clock, synchronous active-high reset
//   REQ/REQ_ADDR/REQ_WRITE/REQ_WDATA : per-requester transfer request (packed)
//   GNT                     : one-cycle pulse in the arbitration (IDLE) cycle
//   DONE/RDATA/RESP_ERR     : completion pulse with read data and error flag
//   TIMEOUT                 : pulses with DONE when the slave never answered
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA/PREADY/PSLVERR : APB3 master port
// ----------------------------------------------------------------------------
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int SEL_MSB        = 27,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*APB_W-1:0] REQ_ADDR,
    input  logic [NREQ-1:0]       REQ_WRITE,
    input  logic [NREQ*APB_W-1:0] REQ_WDATA,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       DONE,
    output logic [APB_W-1:0]      RDATA,
    output logic                  RESP_ERR,
    output logic                  TIMEOUT,
    output logic [APB_W-1:0]      PADDR,
    output logic [PSEL_W-1:0]     PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_W-1:0]      PWDATA,
    input  logic [APB_W-1:0]      PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int IDX_W   = $clog2(NREQ);
    localparam int CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);

    state_e             state_q,    state_d;
    logic [IDX_W-1:0]   ptr_q,      ptr_d;
    logic [IDX_W-1:0]   owner_q,    owner_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [APB_W-1:0]   paddr_q,    paddr_d;
    logic               pwrite_q,   pwrite_d;
    logic [APB_W-1:0]   pwdata_q,   pwdata_d;
    logic [PSEL_W-1:0]  psel_q,     psel_d;
    logic               penable_q,  penable_d;
    logic [APB_W-1:0]   rdata_q,    rdata_d;
    logic               resp_err_q, resp_err_d;
    logic [NREQ-1:0]    done_q,     done_d;
    logic               timeout_q,  timeout_d;

    logic [NREQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [APB_W-1:0]   pick_addr;
    logic [APB_W-1:0]   pick_wdata;
    logic               pick_write;
    logic               to_hit;

    apb_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_addr  = REQ_ADDR[APB_W*int'(pick_idx) +: APB_W];
        pick_wdata = REQ_WDATA[APB_W*int'(pick_idx) +: APB_W];
        pick_write = REQ_WRITE[pick_idx];
    end

    // Last allowed wait cycle: the counter holds the number of PREADY-low
    // ACCESS cycles already spent before the current one.
    assign to_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        done_d     = '0;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
                if (pick_valid) begin
                    owner_d  = pick_idx;
                    ptr_d    = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IDX_W'(1);
                    paddr_d  = pick_addr;
                    pwrite_d = pick_write;
                    pwdata_d = pick_wdata;
                    psel_d   = slot_to_psel(pick_addr[SEL_MSB -: SLOT_W]);
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY || to_hit) begin
                    psel_d          = '0;
                    penable_d       = 1'b0;
                    done_d[owner_q] = 1'b1;
                    state_d         = ST_RESP;
                    if (PREADY) begin
                        rdata_d    = pwrite_q ? '0 : PRDATA;
                        resp_err_d = PSLVERR;
                    end else begin
                        rdata_d    = '0;
                        resp_err_d = 1'b1;
                        timeout_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    // The datapath registers are reset too, because all outputs must read 0.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
            done_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // GNT is the combinational pick in the arbitration cycle; it is held off
    // while reset is asserted so no grant is announced for a discarded cycle.
    assign GNT      = (state_q == ST_IDLE && !PRESET) ? pick_gnt : '0;
    assign DONE     = done_q;
    assign RDATA    = rdata_q;
    assign RESP_ERR = resp_err_q;
    assign TIMEOUT  = timeout_q;
    assign PADDR    = paddr_q;
    assign PSEL     = psel_q;
    assign PENABLE  = penable_q;
    assign PWRITE   = pwrite_q;
    assign PWDATA   = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_master_arbiter
// Directed bench for apb_master_arbiter (NREQ=4, SEL_MSB=27, TIMEOUT_CYCLES=8).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// after a further settle delay. Cycle 0 of each scenario is the IDLE cycle in
// which the request is presented.
// ----------------------------------------------------------------------------
module tb_apb_master_arbiter;

    localparam int NREQ = 4;

    logic                 PCLK;
    logic                 PRESET;
    logic [NREQ-1:0]      REQ;
    logic [NREQ*32-1:0]   REQ_ADDR;
    logic [NREQ-1:0]      REQ_WRITE;
    logic [NREQ*32-1:0]   REQ_WDATA;
    logic [NREQ-1:0]      GNT;
    logic [NREQ-1:0]      DONE;
    logic [31:0]          RDATA;
    logic                 RESP_ERR;
    logic                 TIMEOUT;
    logic [31:0]          PADDR;
    logic [15:0]          PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [31:0]          PWDATA;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    int n_checks;
    int n_errors;

    apb_master_arbiter #(
        .NREQ           (NREQ),
        .SEL_MSB        (27),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .REQ       (REQ),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WRITE (REQ_WRITE),
        .REQ_WDATA (REQ_WDATA),
        .GNT       (GNT),
        .DONE      (DONE),
        .RDATA     (RDATA),
        .RESP_ERR  (RESP_ERR),
        .TIMEOUT   (TIMEOUT),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge PCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        PRESET = 1'b1;
        next_cycle();
        next_cycle();
        PRESET = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        next_cycle();
        next_cycle();
        REQ = 4'b1111;
        settle();
        n_checks++; if (GNT !== 4'b0000) begin n_errors++; $display("FAIL rst_gnt: got %b want %b", GNT, 4'b0000); end
        n_checks++; if (DONE !== 4'b0000) begin n_errors++; $display("FAIL rst_done: got %b want %b", DONE, 4'b0000); end
        n_checks++; if (RDATA !== 32'h0) begin n_errors++; $display("FAIL rst_rdata: got %h want 0", RDATA); end
        n_checks++; if (RESP_ERR !== 1'b0) begin n_errors++; $display("FAIL rst_resp_err: got %b want 0", RESP_ERR); end
        n_checks++; if (TIMEOUT !== 1'b0) begin n_errors++; $display("FAIL rst_timeout: got %b want 0", TIMEOUT); end
        n_checks++; if (PADDR !== 32'h0) begin n_errors++; $display("FAIL rst_paddr: got %h want 0", PADDR); end
        n_checks++; if (PSEL !== 16'h0) begin n_errors++; $display("FAIL rst_psel: got %h want 0", PSEL); end
        n_checks++; if (PENABLE !== 1'b0) begin n_errors++; $display("FAIL rst_penable: got %b want 0", PENABLE); end
        n_checks++; if (PWRITE !== 1'b0) begin n_errors++; $display("FAIL rst_pwrite: got %b want 0", PWRITE); end
        n_checks++; if (PWDATA !== 32'h0) begin n_errors++; $display("FAIL rst_pwdata: got %h want 0", PWDATA); end
        REQ = 4'b0000;
        PRESET = 1'b0;
    endtask

    task automatic test_single_read();
        REQ_ADDR[2*32 +: 32] = 32'h0300_0010;
        REQ_WRITE[2] = 1'b0;
        PRDATA = 32'hDEAD_BEEF;
        PREADY = 1'b1;
        PSLVERR = 1'b0;
        REQ = 4'b0100;
        settle();
        n_checks++; if (GNT !== 4'b0100) begin n_errors++; $display("FAIL rd_gnt_c0: got %b want %b", GNT, 4'b0100); end
        n_checks++; if (PSEL !== 16'h0000) begin n_errors++; $display("FAIL rd_psel_c0: got %h want 0000", PSEL); end
        next_cycle();
        n_checks++; if (PSEL !== 16'h0008) begin n_errors++; $display("FAIL rd_psel_c1: got %h want 0008", PSEL); end
        n_checks++; if (PENABLE !== 1'b0) begin n_errors++; $display("FAIL rd_penable_c1: got %b want 0", PENABLE); end
        n_checks++; if (PADDR !== 32'h0300_0010) begin n_errors++; $display("FAIL rd_paddr_c1: got %h want 03000010", PADDR); end
        n_checks++; if (GNT !== 4'b0000) begin n_errors++; $display("FAIL rd_gnt_c1: got %b want 0000", GNT); end
        next_cycle();
        n_checks++; if (PENABLE !== 1'b1) begin n_errors++; $display("FAIL rd_penable_c2: got %b want 1", PENABLE); end
        n_checks++; if (PSEL !== 16'h0008) begin n_errors++; $display("FAIL rd_psel_c2: got %h want 0008", PSEL); end
        n_checks++; if (DONE !== 4'b0000) begin n_errors++; $display("FAIL rd_done_c2: got %b want 0000", DONE); end
        next_cycle();
        n_checks++; if (DONE !== 4'b0100) begin n_errors++; $display("FAIL rd_done_c3: got %b want 0100", DONE); end
        n_checks++; if (RDATA !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL rd_rdata: got %h want deadbeef", RDATA); end
        n_checks++; if (RESP_ERR !== 1'b0) begin n_errors++; $display("FAIL rd_resp_err: got %b want 0", RESP_ERR); end
        n_checks++; if (TIMEOUT !== 1'b0) begin n_errors++; $display("FAIL rd_timeout: got %b want 0", TIMEOUT); end
        n_checks++; if (PSEL !== 16'h0000) begin n_errors++; $display("FAIL rd_psel_c3: got %h want 0000", PSEL); end
        REQ = 4'b0000;
        next_cycle();
        n_checks++; if (DONE !== 4'b0000) begin n_errors++; $display("FAIL rd_done_c4: got %b want 0000", DONE); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [3:0]  exp_d;
        logic [15:0] exp_sel;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            REQ_ADDR[32*i +: 32] = {4'h0, 4'(i + 4), 24'h00_0100};
            REQ_WRITE[i] = 1'b0;
        end
        PREADY = 1'b1;
        PRDATA = 32'h0000_00A5;
        REQ = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) next_cycle();
            settle();
            exp_g   = (c % 4 == 0) ? 4'(1 << ((c / 4) % 4)) : 4'b0000;
            exp_d   = (c % 4 == 3) ? 4'(1 << ((c / 4) % 4)) : 4'b0000;
            exp_sel = 16'(1 << (((c / 4) % 4) + 4));
            n_checks++; if (GNT !== exp_g) begin n_errors++; $display("FAIL rr_gnt c%0d: got %b want %b", c, GNT, exp_g); end
            n_checks++; if (DONE !== exp_d) begin n_errors++; $display("FAIL rr_done c%0d: got %b want %b", c, DONE, exp_d); end
            if (c % 4 == 1) begin
                n_checks++; if (PSEL !== exp_sel) begin n_errors++; $display("FAIL rr_psel c%0d: got %h want %h", c, PSEL, exp_sel); end
            end
            if (c == 19) REQ = 4'b0000;
        end
        next_cycle();
    endtask

    task automatic test_write_wait();
        REQ_ADDR[32 +: 32]  = 32'h0F00_0000;
        REQ_WRITE[1]        = 1'b1;
        REQ_WDATA[32 +: 32] = 32'h1234_5678;
        PREADY = 1'b0;
        PRDATA = 32'hCAFE_F00D;
        REQ = 4'b0010;
        settle();
        n_checks++; if (GNT !== 4'b0010) begin n_errors++; $display("FAIL wr_gnt: got %b want 0010", GNT); end
        next_cycle();
        n_checks++; if (PSEL !== 16'h8000) begin n_errors++; $display("FAIL wr_psel_c1: got %h want 8000", PSEL); end
        n_checks++; if (PWRITE !== 1'b1) begin n_errors++; $display("FAIL wr_pwrite: got %b want 1", PWRITE); end
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            if (c == 2) begin
                REQ_WDATA[32 +: 32] = 32'h0;
                REQ_ADDR[32 +: 32]  = 32'h0;
            end
            if (c == 5) PREADY = 1'b1;
            settle();
            n_checks++; if (PENABLE !== 1'b1) begin n_errors++; $display("FAIL wr_penable c%0d: got %b want 1", c, PENABLE); end
            n_checks++; if (PSEL !== 16'h8000) begin n_errors++; $display("FAIL wr_psel c%0d: got %h want 8000", c, PSEL); end
            n_checks++; if (PWDATA !== 32'h1234_5678) begin n_errors++; $display("FAIL wr_pwdata c%0d: got %h want 12345678", c, PWDATA); end
            n_checks++; if (PADDR !== 32'h0F00_0000) begin n_errors++; $display("FAIL wr_paddr c%0d: got %h want 0f000000", c, PADDR); end
            n_checks++; if (DONE !== 4'b0000) begin n_errors++; $display("FAIL wr_done_early c%0d: got %b want 0000", c, DONE); end
        end
        next_cycle();
        n_checks++; if (DONE !== 4'b0010) begin n_errors++; $display("FAIL wr_done_c6: got %b want 0010", DONE); end
        n_checks++; if (RDATA !== 32'h0) begin n_errors++; $display("FAIL wr_rdata: got %h want 0", RDATA); end
        n_checks++; if (RESP_ERR !== 1'b0) begin n_errors++; $display("FAIL wr_resp_err: got %b want 0", RESP_ERR); end
        REQ = 4'b0000;
        REQ_WRITE = 4'b0000;
        next_cycle();
    endtask

    task automatic test_slverr();
        REQ_ADDR[3*32 +: 32] = 32'h0500_0000;
        REQ_WRITE[3] = 1'b0;
        PRDATA = 32'h55AA_55AA;
        PREADY = 1'b1;
        PSLVERR = 1'b1;
        REQ = 4'b1000;
        settle();
        n_checks++; if (GNT !== 4'b1000) begin n_errors++; $display("FAIL err_gnt: got %b want 1000", GNT); end
        next_cycle();
        n_checks++; if (PSEL !== 16'h0020) begin n_errors++; $display("FAIL err_psel: got %h want 0020", PSEL); end
        next_cycle();
        next_cycle();
        n_checks++; if (DONE !== 4'b1000) begin n_errors++; $display("FAIL err_done: got %b want 1000", DONE); end
        n_checks++; if (RESP_ERR !== 1'b1) begin n_errors++; $display("FAIL err_resp_err: got %b want 1", RESP_ERR); end
        n_checks++; if (TIMEOUT !== 1'b0) begin n_errors++; $display("FAIL err_timeout: got %b want 0", TIMEOUT); end
        n_checks++; if (RDATA !== 32'h55AA_55AA) begin n_errors++; $display("FAIL err_rdata: got %h want 55aa55aa", RDATA); end
        REQ = 4'b0000;
        PSLVERR = 1'b0;
        next_cycle();
    endtask

    task automatic test_timeout();
        REQ_ADDR[0 +: 32] = 32'h0100_0000;
        REQ_WRITE[0] = 1'b0;
        PREADY = 1'b0;
        PRDATA = 32'h1111_2222;
        REQ = 4'b0001;
        settle();
        n_checks++; if (GNT !== 4'b0001) begin n_errors++; $display("FAIL to_gnt: got %b want 0001", GNT); end
        next_cycle();
        for (int c = 2; c <= 9; c++) begin
            next_cycle();
            n_checks++; if (PENABLE !== 1'b1) begin n_errors++; $display("FAIL to_penable c%0d: got %b want 1", c, PENABLE); end
            n_checks++; if (DONE !== 4'b0000) begin n_errors++; $display("FAIL to_done_early c%0d: got %b want 0000", c, DONE); end
            n_checks++; if (TIMEOUT !== 1'b0) begin n_errors++; $display("FAIL to_timeout_early c%0d: got %b want 0", c, TIMEOUT); end
        end
        next_cycle();
        n_checks++; if (DONE !== 4'b0001) begin n_errors++; $display("FAIL to_done: got %b want 0001", DONE); end
        n_checks++; if (TIMEOUT !== 1'b1) begin n_errors++; $display("FAIL to_timeout: got %b want 1", TIMEOUT); end
        n_checks++; if (RESP_ERR !== 1'b1) begin n_errors++; $display("FAIL to_resp_err: got %b want 1", RESP_ERR); end
        n_checks++; if (RDATA !== 32'h0) begin n_errors++; $display("FAIL to_rdata: got %h want 0", RDATA); end
        n_checks++; if (PSEL !== 16'h0000) begin n_errors++; $display("FAIL to_psel: got %h want 0000", PSEL); end
        REQ = 4'b0000;
        PREADY = 1'b1;
        next_cycle();
        n_checks++; if (TIMEOUT !== 1'b0) begin n_errors++; $display("FAIL to_pulse_width: got %b want 0", TIMEOUT); end
        n_checks++; if (DONE !== 4'b0000) begin n_errors++; $display("FAIL to_done_width: got %b want 0000", DONE); end
        // Next request must be served normally.
        REQ_ADDR[32 +: 32] = 32'h0200_0000;
        REQ_WRITE[1] = 1'b0;
        PRDATA = 32'h0BAD_F00D;
        REQ = 4'b0010;
        settle();
        n_checks++; if (GNT !== 4'b0010) begin n_errors++; $display("FAIL to_next_gnt: got %b want 0010", GNT); end
        next_cycle();
        next_cycle();
        next_cycle();
        n_checks++; if (DONE !== 4'b0010) begin n_errors++; $display("FAIL to_next_done: got %b want 0010", DONE); end
        n_checks++; if (RESP_ERR !== 1'b0) begin n_errors++; $display("FAIL to_next_resp_err: got %b want 0", RESP_ERR); end
        n_checks++; if (TIMEOUT !== 1'b0) begin n_errors++; $display("FAIL to_next_timeout: got %b want 0", TIMEOUT); end
        n_checks++; if (RDATA !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL to_next_rdata: got %h want 0badf00d", RDATA); end
        REQ = 4'b0000;
        next_cycle();
    endtask

    task automatic test_reset_mid_transfer();
        // Pointer is 2 here; a grant to requester 1 leaves it at 2 as well, so
        // only a pointer reset lets requester 0 beat requester 2 afterwards.
        REQ_ADDR[0 +: 32]    = 32'h0100_0000;
        REQ_ADDR[32 +: 32]   = 32'h0200_0000;
        REQ_ADDR[2*32 +: 32] = 32'h0300_0000;
        REQ_WRITE = 4'b0000;
        PREADY = 1'b0;
        REQ = 4'b0010;
        settle();
        n_checks++; if (GNT !== 4'b0010) begin n_errors++; $display("FAIL mid_gnt: got %b want 0010", GNT); end
        next_cycle();
        next_cycle();
        next_cycle();
        n_checks++; if (PENABLE !== 1'b1) begin n_errors++; $display("FAIL mid_penable_pre: got %b want 1", PENABLE); end
        PRESET = 1'b1;
        next_cycle();
        PRESET = 1'b0;
        PREADY = 1'b1;
        REQ = 4'b0101;
        settle();
        n_checks++; if (PSEL !== 16'h0000) begin n_errors++; $display("FAIL mid_psel: got %h want 0000", PSEL); end
        n_checks++; if (PENABLE !== 1'b0) begin n_errors++; $display("FAIL mid_penable: got %b want 0", PENABLE); end
        n_checks++; if (DONE !== 4'b0000) begin n_errors++; $display("FAIL mid_done: got %b want 0000", DONE); end
        n_checks++; if (GNT !== 4'b0001) begin n_errors++; $display("FAIL mid_ptr_gnt: got %b want 0001", GNT); end
        next_cycle();
        REQ = 4'b0000;
        n_checks++; if (PSEL !== 16'h0002) begin n_errors++; $display("FAIL mid_psel_new: got %h want 0002", PSEL); end
        next_cycle();
        next_cycle();
        n_checks++; if (DONE !== 4'b0001) begin n_errors++; $display("FAIL mid_done_new: got %b want 0001", DONE); end
        next_cycle();
        n_checks++; if (DONE !== 4'b0000) begin n_errors++; $display("FAIL mid_no_stale_done: got %b want 0000", DONE); end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        PRESET    = 1'b1;
        REQ       = '0;
        REQ_ADDR  = '0;
        REQ_WRITE = '0;
        REQ_WDATA = '0;
        PRDATA    = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;

        test_reset();
        test_single_read();
        test_round_robin();
        test_write_wait();
        test_slverr();
        test_timeout();
        test_reset_mid_transfer();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
